// File: rtl/fcvt_seq_ctrl.sv
// fcvt_seq_ctrl: multi-cycle sequencer converting a 32-bit signed or unsigned
// integer to an IEEE-754 single-precision value with round-to-nearest-even.
// Flow per op: IDLE -> ABS -> NORM (0..n cycles) -> RND -> DONE -> IDLE.
// The operand is normalised by a bounded left shifter (at most NORM_STEP bits
// per cycle), so the NORM cycle count depends on the operand's leading zeros.
module fcvt_seq_ctrl #(
   parameter int unsigned NORM_STEP = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        kill,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_unsigned,
   input  logic [31:0] in_rs1,
   input  logic [4:0]  in_rd,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [4:0]  out_rd,
   output logic        out_nx,
   output logic        busy
);

   // Shift limit as a 6-bit value so it compares directly against the lzc.
   localparam logic [5:0] STEP = 6'(NORM_STEP);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ABS  = 3'd1,
      ST_NORM = 3'd2,
      ST_RND  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t      state_reg,    state_next;
   logic        unsigned_reg, unsigned_next;
   logic        sign_reg,     sign_next;
   logic        zero_reg,     zero_next;
   logic [31:0] mag_reg,      mag_next;
   logic [4:0]  rd_reg,       rd_next;
   logic [5:0]  lz_reg,       lz_next;
   logic [31:0] result_reg,   result_next;
   logic        nx_reg,       nx_next;

   // Datapath helper signals
   logic [31:0] hi_or;
   logic [5:0]  lzc;
   logic [5:0]  shift_amt;
   logic [31:0] mag_shl;
   logic        abs_sign;
   logic [31:0] abs_mag;
   logic        guard_bit;
   logic        sticky_bit;
   logic        round_up;
   logic [23:0] mant_sum;
   logic [7:0]  exp_base;
   logic [7:0]  exp_fin;

   // hi_or[i] is set when any bit at or above position i of the magnitude is 1;
   // the leading-zero count is the number of positions where it is still clear.
   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_hi_or
         assign hi_or[gi] = |mag_reg[31:gi];
      end
   endgenerate

   // Leading-zero count of the current magnitude.
   always_comb begin
      lzc = 6'd0;
      for (int i = 0; i < 32; i++) begin
         if (!hi_or[i]) begin
            lzc = lzc + 6'd1;
         end
      end
   end

   // Bounded normalisation shift and the absolute-value step.
   assign shift_amt = (lzc < STEP) ? lzc : STEP;
   assign mag_shl   = mag_reg << shift_amt;
   assign abs_sign  = ~unsigned_reg & mag_reg[31];
   assign abs_mag   = abs_sign ? (~mag_reg + 32'd1) : mag_reg;

   // RNE rounding of the normalised magnitude; the hidden bit is mag_reg[31].
   assign guard_bit  = mag_reg[7];
   assign sticky_bit = |mag_reg[6:0];
   assign round_up   = guard_bit & (sticky_bit | mag_reg[8]);
   assign mant_sum   = {1'b0, mag_reg[30:8]} + {23'd0, round_up};
   assign exp_base   = 8'd158 - {2'b00, lz_reg};
   assign exp_fin    = exp_base + {7'd0, mant_sum[23]};

   // Next-state and datapath-update logic; kill overrides everything.
   always_comb begin
      state_next    = state_reg;
      unsigned_next = unsigned_reg;
      sign_next     = sign_reg;
      zero_next     = zero_reg;
      mag_next      = mag_reg;
      rd_next       = rd_reg;
      lz_next       = lz_reg;
      result_next   = result_reg;
      nx_next       = nx_reg;

      if (kill) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (in_valid) begin
                  unsigned_next = in_unsigned;
                  mag_next      = in_rs1;
                  rd_next       = in_rd;
                  lz_next       = 6'd0;
                  state_next    = ST_ABS;
               end
            end
            ST_ABS: begin
               sign_next = abs_sign;
               mag_next  = abs_mag;
               zero_next = (abs_mag == 32'd0);
               if ((abs_mag == 32'd0) || abs_mag[31]) begin
                  state_next = ST_RND;
               end else begin
                  state_next = ST_NORM;
               end
            end
            ST_NORM: begin
               mag_next = mag_shl;
               lz_next  = lz_reg + shift_amt;
               if (mag_shl[31]) begin
                  state_next = ST_RND;
               end
            end
            ST_RND: begin
               if (zero_reg) begin
                  result_next = 32'd0;
                  nx_next     = 1'b0;
               end else begin
                  // A mantissa carry leaves mant_sum[22:0] all zero already.
                  result_next = {sign_reg, exp_fin, mant_sum[22:0]};
                  nx_next     = guard_bit | sticky_bit;
               end
               state_next = ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_next = ST_IDLE;
               end
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg    <= ST_IDLE;
         unsigned_reg <= 1'b0;
         sign_reg     <= 1'b0;
         zero_reg     <= 1'b0;
         mag_reg      <= 32'd0;
         rd_reg       <= 5'd0;
         lz_reg       <= 6'd0;
         result_reg   <= 32'd0;
         nx_reg       <= 1'b0;
      end else begin
         state_reg    <= state_next;
         unsigned_reg <= unsigned_next;
         sign_reg     <= sign_next;
         zero_reg     <= zero_next;
         mag_reg      <= mag_next;
         rd_reg       <= rd_next;
         lz_reg       <= lz_next;
         result_reg   <= result_next;
         nx_reg       <= nx_next;
      end
   end

   assign in_ready   = (state_reg == ST_IDLE);
   assign out_valid  = (state_reg == ST_DONE);
   assign busy       = (state_reg != ST_IDLE);
   assign out_result = result_reg;
   assign out_rd     = rd_reg;
   assign out_nx     = nx_reg;

endmodule
